mc_traffic_gen: RTL

//  Scheduled read/write request generator with a self-checking scoreboard for the memory controller.

---
 rtl/mc_traffic_gen.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_traffic_gen.sv
// Scheduled read/write traffic generator for the memory controller, with a
// direct-mapped shadow scoreboard that checks read data against the last write.

package mc_package;
    localparam int ADDRWIDTH = 12;
    localparam int DATAWIDTH = 16;
endpackage

module mc_traffic_gen
    import mc_package::*;
#(
    parameter int AW      = ADDRWIDTH,
    parameter int DW      = DATAWIDTH,
    parameter int QDEPTH  = 16,
    parameter int TICKW   = 32,
    parameter int SB_AW   = 6,
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [TICKW-1:0] CmdTick,
    input  logic             CmdOp,
    input  logic [AW-1:0]    CmdAddr,
    input  logic [DW-1:0]    CmdData,
    output logic [AW-1:0]    Addr,
    output logic [DW-1:0]    WrData,
    output logic             Rd_Wr,
    output logic             valid,
    input  logic [DW-1:0]    RdData,
    input  logic             Ready,
    output logic             Done,
    output logic             Mismatch,
    output logic             TimeoutPulse,
    output logic [CNTW-1:0]  IssuedCount,
    output logic [CNTW-1:0]  ErrCount,
    output logic [CNTW-1:0]  UnknownCount,
    output logic [CNTW-1:0]  TimeoutCount
);

    localparam int PW   = $clog2(QDEPTH);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int TAGW = AW - SB_AW;
    localparam int SB_N = 1 << SB_AW;

    typedef enum logic {IDLE, REQ} state_t;

    typedef struct packed {
        logic [TICKW-1:0] tick;
        logic             op;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
    } cmd_t;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNTW'(1) : v;
    endfunction

    // ---------------- command FIFO ----------------
    cmd_t          fifo_mem [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_count;
    logic          fifo_full, fifo_empty, push, pop;
    cmd_t          head;

    assign fifo_full  = (fifo_count == (PW+1)'(QDEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign CmdReady   = ~fifo_full;
    assign push       = CmdValid & ~fifo_full;
    assign head       = fifo_mem[rd_ptr];

    // NOTE: <= in every clocked block so all registers update from pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: storage arrays carry no reset; pointers and valid bits decide what is live.
    always_ff @(posedge Clock) begin
        if (push) fifo_mem[wr_ptr] <= '{tick: CmdTick, op: CmdOp, addr: CmdAddr, data: CmdData};
    end

    // ---------------- tick counter ----------------
    logic [TICKW-1:0] tick_count;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                          tick_count <= '0;
        else if (Enable && tick_count != '1) tick_count <= tick_count + TICKW'(1);
    end

    // ---------------- request FSM ----------------
    state_t        state, state_next;
    logic [TW-1:0] req_timer;
    logic          complete, timeout;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && Enable && (tick_count >= head.tick)) begin
                    pop        = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // Ready on the last allowed cycle still wins over the timeout.
                if (Ready) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (req_timer == TW'(TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            req_timer <= '0;
            valid     <= 1'b0;
            Rd_Wr     <= 1'b0;
            Addr      <= '0;
            WrData    <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                valid     <= 1'b1;
                Rd_Wr     <= head.op;
                Addr      <= head.addr;
                WrData    <= head.data;
                req_timer <= '0;
            end else if (complete || timeout) begin
                valid <= 1'b0;
            end else if (state == REQ) begin
                req_timer <= req_timer + TW'(1);
            end
        end
    end

    assign Done = fifo_empty && (state == IDLE);

    // ---------------- shadow scoreboard ----------------
    logic [SB_N-1:0] sb_valid;
    logic [TAGW-1:0] sb_tag  [SB_N];
    logic [DW-1:0]   sb_data [SB_N];
    logic [SB_AW-1:0] sb_idx;
    logic            sb_hit, rd_done, wr_done, mismatch_now, unknown_now;

    assign sb_idx       = Addr[SB_AW-1:0];
    assign sb_hit       = sb_valid[sb_idx] && (sb_tag[sb_idx] == Addr[AW-1:SB_AW]);
    assign rd_done      = complete && !Rd_Wr;
    assign wr_done      = complete && Rd_Wr;
    assign mismatch_now = rd_done && sb_hit && (sb_data[sb_idx] != RdData);
    assign unknown_now  = rd_done && !sb_hit;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)        sb_valid         <= '0;
        else if (wr_done) sb_valid[sb_idx] <= 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (wr_done) begin
            sb_tag[sb_idx]  <= Addr[AW-1:SB_AW];
            sb_data[sb_idx] <= WrData;
        end
    end

    // ---------------- status pulses and counters ----------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Mismatch     <= 1'b0;
            TimeoutPulse <= 1'b0;
            IssuedCount  <= '0;
            ErrCount     <= '0;
            UnknownCount <= '0;
            TimeoutCount <= '0;
        end else begin
            Mismatch     <= mismatch_now;
            TimeoutPulse <= timeout;
            IssuedCount  <= sat_inc(IssuedCount, complete);
            ErrCount     <= sat_inc(ErrCount, mismatch_now);
            UnknownCount <= sat_inc(UnknownCount, unknown_now);
            TimeoutCount <= sat_inc(TimeoutCount, timeout);
        end
    end

endmodule
